scan_chain_tester: RTL

Scan-test initiator for the 8-bit scan chain block. It accepts a test pattern through a start/busy handshake, serially loads it into the chain with `scan_en` high, and issues one capture cycle with `scan_en` low. It then unloads the captured chain contents through `scan_out` and presents them in parallel with a one-cycle `done` pulse. The block sits between a test sequencer (or top-level switches) and the chain, replacing hand-driven bench stimulus with a reusable, cycle-exact driver.

---
 rtl/scan_chain_tester_if.sv | 32 +++
 rtl/scan_chain_tester.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/scan_chain_tester_if.sv
// rtl/scan_chain_tester_if.sv - sequencer-side handshake bundle for scan_chain_tester
//
// Purpose: groups the start/busy request, load pattern and unloaded response
// between a test sequencer (master) and scan_chain_tester (slave).
// Signals:
//   start    - request a test (sampled while busy=0)
//   pattern  - CHAIN_LEN-bit load vector, sampled on the accepting edge
//   busy     - test in progress
//   done     - one-cycle pulse when resp becomes valid
//   resp     - CHAIN_LEN-bit unloaded response, held until next accepted start
//   exp      - expected response (SCAN_CMP_EN builds only)
//   mismatch - resp != exp, valid with done and held (SCAN_CMP_EN builds only)
// Optional feature macro: SCAN_CMP_EN
interface scan_chain_tester_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] resp;
`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp;
    logic                 mismatch;

    modport master (output start, pattern, exp, input busy, done, resp, mismatch);
    modport slave  (input start, pattern, exp, output busy, done, resp, mismatch);
`else
    modport master (output start, pattern, input busy, done, resp);
    modport slave  (input start, pattern, output busy, done, resp);
`endif
endinterface

// File: rtl/scan_chain_tester.sv
// rtl/scan_chain_tester.sv - scan-test initiator: load, capture, unload one chain
//
// Purpose: accepts a pattern over the start/busy handshake, shifts it MSB first
// into the attached chain with scan_en=1, issues one capture cycle with
// scan_en=0, shifts the captured contents back out and presents them on resp
// with a one-cycle done pulse. Latency from accepting edge to done is
// 2*CHAIN_LEN+1 cycles.
// Ports:
//   clk      - clock, all state changes on posedge
//   rst      - asynchronous active-high reset
//   bus      - scan_chain_tester_if.slave (start/pattern/busy/done/resp
//              and, with SCAN_CMP_EN, exp/mismatch)
//   scan_in  - registered serial data to the chain
//   scan_en  - registered chain mode, 1 = shift, 0 = capture
//   scan_out - serial data from the chain's last flop
// Optional feature macro: SCAN_CMP_EN (latches exp at start, flags resp != exp)
module scan_chain_tester #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    scan_chain_tester_if.slave    bus,
    output logic                  scan_in,
    output logic                  scan_en,
    input  logic                  scan_out
);
    localparam int CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, UNLOAD} state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CHAIN_LEN-1:0] resp_shift;
    logic                 busy_q;
    logic                 done_q;
    logic                 scan_in_d;
    logic                 scan_en_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 last;
    logic                 accept;

    assign last       = (cnt == CW'(CHAIN_LEN - 1));
    assign accept     = (state == IDLE) && bus.start;
    assign resp_shift = {resp_q[CHAIN_LEN-2:0], scan_out};

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.resp = resp_q;

`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic                 mismatch_q;

    assign bus.mismatch = mismatch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (accept) begin
            exp_q      <= bus.exp;
            mismatch_q <= 1'b0;
        end else if (state == UNLOAD && last) begin
            // Compare against the value resp takes on this same edge.
            mismatch_q <= (resp_shift != exp_q);
        end
    end
`endif

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            resp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scan_in <= 1'b0;
            scan_en <= 1'b0;
        end else begin
            state   <= state_next;
            busy_q  <= busy_d;
            done_q  <= done_d;
            scan_in <= scan_in_d;
            scan_en <= scan_en_d;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // MSB goes out directly on this edge; sreg holds the rest.
                        sreg   <= bus.pattern << 1;
                        cnt    <= '0;
                        resp_q <= '0;
                    end
                end
                LOAD: begin
                    sreg <= sreg << 1;
                    cnt  <= last ? '0 : cnt + CW'(1);
                end
                CAPTURE: begin
                    cnt <= '0;
                end
                UNLOAD: begin
                    resp_q <= resp_shift;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (last)      state_next = CAPTURE;
            CAPTURE:                state_next = UNLOAD;
            UNLOAD:  if (last)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic: values the output registers take on the coming edge, so the
    // chain sees stable scan_in/scan_en for a whole cycle.
    always_comb begin
        scan_in_d = 1'b0;
        scan_en_d = 1'b0;
        busy_d    = (state_next != IDLE);
        done_d    = (state == UNLOAD) && (state_next == IDLE);
        if (state_next == LOAD) begin
            scan_en_d = 1'b1;
            scan_in_d = (state == IDLE) ? bus.pattern[CHAIN_LEN-1] : sreg[CHAIN_LEN-1];
        end else if (state_next == UNLOAD) begin
            scan_en_d = 1'b1;
        end
    end
endmodule
